// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Contents: supported opcodes, the FSM state encoding, ALUOp codes,
// ALUControl codes and the datapath select encodings (ImmSrc, ResultSrc,
// ALUSrcA, ALUSrcB), plus a helper that flags supported opcodes.
package riscv_ctrl_pkg;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Main FSM states, binary encoded
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    // Operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate extender select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMMEXT = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // True when the opcode is one this controller can sequence
    function automatic logic is_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_R, OP_IALU, OP_BRANCH, OP_JAL: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// Instruction fields and the ALU zero flag flow from the datapath to the
// controller; every select and write enable flows back.
//   master: controller side (drives the controls)
//   slave : datapath side (drives instruction fields and zero)
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: turns the FSM's operation class plus instruction fields into
// the 3-bit ALUControl code. Purely combinational.
// Ports: aluop (class from FSM), funct3, op5 (instr[5]), funct7b5 (instr[30]),
//        alu_control (ALUControl out).
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // ALUControl selection; sub only for R-type (op5=1) with funct7b5 set
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 & funct7b5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit.
// Sequences each instruction through FETCH/DECODE/... states, drives all
// datapath selects and enables as Moore outputs (plus the branch decision
// from zero), decodes ImmSrc from op, flags unsupported opcodes and counts
// retired instructions.
// Ports: clk, rst_n (async active-low), bus (controller modport of
//        multicycle_controller_if), illegal_op (DECODE pulse for an
//        unsupported opcode), instret (retired-instruction count).
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_controller_if.master bus,
    output logic                 illegal_op,
    output logic [INSTRET_W-1:0] instret
);

    state_t               state_r;
    state_t               next_state_s;
    logic [INSTRET_W-1:0] instret_r;
    logic                 retire_s;

    logic       pc_update_s;
    logic       branch_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    aluop_t     aluop_s;
    logic [2:0] alu_control_s;
    logic [1:0] imm_src_s;
    logic       illegal_s;

    // State register; reset parks the FSM in FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: next_state_s = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXECR;
                    OP_IALU:      next_state_s = S_EXECI;
                    OP_JAL:       next_state_s = S_JAL;
                    OP_BRANCH:    next_state_s = S_BRANCH;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD:                   next_state_s = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL:     next_state_s = S_ALUWB;
            S_MEMWB, S_MEMWRITE,
            S_ALUWB, S_BRANCH:           next_state_s = S_FETCH;
            default:                     next_state_s = S_FETCH;
        endcase
    end

    // Moore outputs per state
    always_comb begin
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RD2;
        aluop_s      = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
                pc_update_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMMEXT;
            end
            S_MEMADR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMMEXT;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_RD2;
                aluop_s     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_IMMEXT;
                aluop_s     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                pc_update_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = SRCA_RD1;
                alu_src_b_s = SRCB_RD2;
                aluop_s     = ALUOP_SUB;
                branch_s    = 1'b1;
            end
            default: begin
                pc_update_s = 1'b0;
            end
        endcase
    end

    // Immediate format follows op in every state, independent of the FSM
    always_comb begin
        imm_src_s = IMM_I;
        case (bus.op)
            OP_LW, OP_IALU: imm_src_s = IMM_I;
            OP_SW:          imm_src_s = IMM_S;
            OP_BRANCH:      imm_src_s = IMM_B;
            OP_JAL:         imm_src_s = IMM_J;
            default:        imm_src_s = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop_s),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control_s)
    );

    // An unsupported op goes DECODE->FETCH, so no write state is ever reached
    assign illegal_s = (state_r == S_DECODE) & ~is_supported(bus.op);

    // Retirement happens on the edge leaving the last state of an instruction
    assign retire_s = (state_r == S_MEMWB) | (state_r == S_MEMWRITE) |
                      (state_r == S_ALUWB) | (state_r == S_BRANCH);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // Write enables are held off while reset is asserted even though the
    // FSM already sits in FETCH; selects simply show their FETCH values.
    // beq (funct3[0]=0) takes the branch on zero, bne on !zero.
    assign bus.PCWrite    = rst_n & (pc_update_s |
                            (branch_s & (bus.zero ^ bus.funct3[0])));
    assign bus.IRWrite    = rst_n & ir_write_s;
    assign bus.RegWrite   = rst_n & reg_write_s;
    assign bus.MemWrite   = rst_n & mem_write_s;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ALUControl = alu_control_s;
    assign bus.ImmSrc     = imm_src_s;
    assign illegal_op     = rst_n & illegal_s;
    assign instret        = instret_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: each table row is one clock
// cycle of inputs and the hand-computed outputs for that cycle.
module tb_multicycle_controller;

    localparam int OP_LW  = 'h03;
    localparam int OP_SW  = 'h23;
    localparam int OP_R   = 'h33;
    localparam int OP_I   = 'h13;
    localparam int OP_BR  = 'h63;
    localparam int OP_JAL = 'h6F;
    localparam int OP_BAD = 'h7F;

    typedef struct packed {
        logic        pcw;
        logic        adr;
        logic        mw;
        logic        irw;
        logic        rw;
        logic [1:0]  rs;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [2:0]  ac;
        logic [1:0]  imm;
        logic        ill;
        logic [31:0] ir;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        out_t       exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        illegal_op;
    logic [31:0] instret;
    out_t        act;
    int          n_vec;
    int          n_mis;
    vec_t        tbl[$];

    multicycle_controller_if bus();

    multicycle_controller #(.INSTRET_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .illegal_op (illegal_op),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                  bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                  bus.ImmSrc, illegal_op, instret};

    function automatic vec_t mk(int op, int f3, int f7, int z,
                                int pcw, int adr, int mw, int irw, int rw,
                                int rs, int sa, int sb, int ac, int imm, int ill, int ir);
        vec_t v;
        v.op      = 7'(op);
        v.f3      = 3'(f3);
        v.f7      = 1'(f7);
        v.z       = 1'(z);
        v.exp.pcw = 1'(pcw);
        v.exp.adr = 1'(adr);
        v.exp.mw  = 1'(mw);
        v.exp.irw = 1'(irw);
        v.exp.rw  = 1'(rw);
        v.exp.rs  = 2'(rs);
        v.exp.sa  = 2'(sa);
        v.exp.sb  = 2'(sb);
        v.exp.ac  = 3'(ac);
        v.exp.imm = 2'(imm);
        v.exp.ill = 1'(ill);
        v.exp.ir  = 32'(ir);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.op       = v.op;
        bus.funct3   = v.f3;
        bus.funct7b5 = v.f7;
        bus.zero     = v.z;
    endtask

    task automatic cmp(input string name, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (pcw adr mw irw rw rs sa sb ac imm ill instret)",
                     name, act, exp);
        end
    endtask

    // One cycle: inputs change 2 time units after the edge, sampled 1 later
    task automatic apply(input string name, input vec_t v);
        drive(v);
        #1;
        cmp(name, v.exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        vec_t v;
        n_vec = 0;
        n_mis = 0;

        //          op      f3 f7 z  pcw adr mw irw rw rs sa sb ac imm ill ir
        // lw x5,8(x0)
        tbl.push_back(mk(OP_LW,  2, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LW,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LW,  2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LW,  2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LW,  2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // sw
        tbl.push_back(mk(OP_SW,  2, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 1, 0, 1));
        tbl.push_back(mk(OP_SW,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(OP_SW,  2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 1));
        tbl.push_back(mk(OP_SW,  2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // R add
        tbl.push_back(mk(OP_R,   0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 2));
        tbl.push_back(mk(OP_R,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk(OP_R,   0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2));
        tbl.push_back(mk(OP_R,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        // R sub
        tbl.push_back(mk(OP_R,   0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 3));
        tbl.push_back(mk(OP_R,   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3));
        tbl.push_back(mk(OP_R,   0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 3));
        tbl.push_back(mk(OP_R,   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3));
        // R and
        tbl.push_back(mk(OP_R,   7, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 4));
        tbl.push_back(mk(OP_R,   7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4));
        tbl.push_back(mk(OP_R,   7, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 4));
        tbl.push_back(mk(OP_R,   7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4));
        // R or
        tbl.push_back(mk(OP_R,   6, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 5));
        tbl.push_back(mk(OP_R,   6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5));
        tbl.push_back(mk(OP_R,   6, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 0, 0, 5));
        tbl.push_back(mk(OP_R,   6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5));
        // R slt
        tbl.push_back(mk(OP_R,   2, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 6));
        tbl.push_back(mk(OP_R,   2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6));
        tbl.push_back(mk(OP_R,   2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 5, 0, 0, 6));
        tbl.push_back(mk(OP_R,   2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6));
        // addi with funct7b5=1 stays add
        tbl.push_back(mk(OP_I,   0, 1, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 7));
        tbl.push_back(mk(OP_I,   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 7));
        tbl.push_back(mk(OP_I,   0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 7));
        tbl.push_back(mk(OP_I,   0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7));
        // beq, zero=1: taken
        tbl.push_back(mk(OP_BR,  0, 0, 1, 1, 0, 0, 1, 0, 2, 0, 2, 0, 2, 0, 8));
        tbl.push_back(mk(OP_BR,  0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 8));
        tbl.push_back(mk(OP_BR,  0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0, 8));
        // bne, zero=1: not taken
        tbl.push_back(mk(OP_BR,  1, 0, 1, 1, 0, 0, 1, 0, 2, 0, 2, 0, 2, 0, 9));
        tbl.push_back(mk(OP_BR,  1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 9));
        tbl.push_back(mk(OP_BR,  1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0, 9));
        // jal
        tbl.push_back(mk(OP_JAL, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 3, 0, 10));
        tbl.push_back(mk(OP_JAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 10));
        tbl.push_back(mk(OP_JAL, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0, 10));
        tbl.push_back(mk(OP_JAL, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 10));
        // illegal 0x7F: FETCH, DECODE (flagged), back to FETCH, not counted
        tbl.push_back(mk(OP_BAD, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 11));
        tbl.push_back(mk(OP_BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 11));
        // beq, zero=0: not taken
        tbl.push_back(mk(OP_BR,  0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 2, 0, 11));
        tbl.push_back(mk(OP_BR,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 11));
        tbl.push_back(mk(OP_BR,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0, 11));
        // bne, zero=0: taken
        tbl.push_back(mk(OP_BR,  1, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 2, 0, 12));
        tbl.push_back(mk(OP_BR,  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 12));
        tbl.push_back(mk(OP_BR,  1, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0, 12));

        // Reset held: enables forced off, FETCH selects, ImmSrc follows op
        rst_n = 1'b0;
        drive(mk(OP_JAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        cmp("reset_jal", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 3, 0, 0).exp);
        @(posedge clk);
        #2;
        drive(mk(OP_BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        cmp("reset_hold_bad", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0).exp);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("row%0d", i), tbl[i]);
        end

        // lw interrupted by reset in MEMREAD
        apply("rst_lw_fetch",  mk(OP_LW, 2, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 13));
        apply("rst_lw_decode", mk(OP_LW, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 13));
        apply("rst_lw_memadr", mk(OP_LW, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 13));
        v = mk(OP_LW, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13);
        drive(v);
        #1;
        cmp("rst_lw_memread", v.exp);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0).exp);
        @(posedge clk);
        #2;
        cmp("reset_no_memwb", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0).exp);
        @(negedge clk);
        rst_n = 1'b1;

        // Next instruction runs normally from FETCH
        apply("post_fetch",  mk(OP_R,  0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0));
        apply("post_decode", mk(OP_R,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        apply("post_execr",  mk(OP_R,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        apply("post_aluwb",  mk(OP_R,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        apply("post_next",   mk(OP_LW, 2, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over several clock cycles per instruction, and drives every datapath select and write enable. It also produces `ImmSrc` for the immediate extender, using the extender's encoding (I=00, S=01, B=10, J=11). It sits beside the datapath, takes only instruction fields and the ALU `zero` flag, and counts retired instructions.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU result equals 0.
- `PCWrite`, `AdrSrc`, `MemWrite`, `IRWrite`, `RegWrite` out 1 each: datapath enables and selects.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: extender select.
- `illegal_op` out 1: single-cycle pulse on an unsupported opcode.
- `instret` out INSTRET_W: retired-instruction count.

## Operation
- **Supported opcodes:**
  - lw 0000011
  - sw 0100011
  - R 0110011
  - I-ALU 0010011
  - branch 1100011 (beq funct3=000, bne funct3=001)
  - jal 1101111
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXECR for R, EXECI for I-ALU, JAL for jal, BRANCH for branch, FETCH for anything else.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB.
  - EXECR, EXECI and JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH→FETCH.
- **Moore outputs per state** (signals not listed are 0 or 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1.
- **PC write:** PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])).
- **ImmSrc:** combinational from `op` in every state.
  - lw and I-ALU → 00.
  - sw → 01.
  - branch → 10.
  - jal → 11.
  - other opcodes → 00.
- **ALU decode** (ALUOp = add, sub or funct):
  - funct3 000 → sub if op[5]&funct7b5, else add.
  - funct3 010 → slt.
  - funct3 110 → or.
  - funct3 111 → and.
  - other funct3 → add.
- **illegal_op:** high during DECODE when `op` is unsupported. No RegWrite, MemWrite or PCWrite is asserted for that instruction.
- **instret:**
  - Increments by 1 on each clock edge that leaves MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^INSTRET_W.
  - Illegal opcodes are not counted.

## Timing
- State register and `instret` use asynchronous reset: rst_n low → state=FETCH and instret=0 immediately.
- While rst_n is low:
  - PCWrite, IRWrite, RegWrite, MemWrite and illegal_op are forced to 0.
  - Select outputs show their FETCH values.
  - ALUControl=000; ImmSrc still follows `op`.
- Reset asserted mid-instruction abandons that instruction. The first cycle after release is FETCH.
- Cycles per instruction: lw 5; sw, R, I-ALU and jal 4; branch 3; illegal 2.
- All outputs are combinational from the state and the current instruction fields. There is no output register, so zero added latency.
- `zero` is sampled combinationally in BRANCH only.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - the state enum (binary, 4 bits);
  - ALUOp codes;
  - ALUControl codes;
  - ImmSrc, ResultSrc, ALUSrcA and ALUSrcB codes.
- Sub-module `alu_decoder`: combinational, mapping ALUOp, funct3, op[5] and funct7b5 to ALUControl. It is instantiated once.
- The FSM, ImmSrc decode and instret counter live in `multicycle_controller`.

## Test plan
- **lw x5,8(x0) (0x00802283):**
  - States go FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - ImmSrc=00 throughout; RegWrite=1 with ResultSrc=01 only in cycle 5.
  - instret goes 0→1.
- **beq with zero=1, then bne with zero=1:**
  - beq: PCWrite=1 in BRANCH (cycle 3).
  - bne: PCWrite=0 in BRANCH.
  - ImmSrc=10 for both; each takes 3 cycles.
- **ALU decode:**
  - R-type funct3=000, funct7b5=1 → ALUControl=001 in EXECR.
  - addi with funct7b5=1 → ALUControl=000 in EXECI.
  - R-type funct3=111 → 010.
- **jal:** JAL state has PCUpdate=1 and ALUSrcB=10; ALUWB has RegWrite=1; ImmSrc=11; total 4 cycles.
- **Illegal opcode 0x7F:**
  - Sequence is FETCH, DECODE, FETCH.
  - illegal_op=1 for exactly the DECODE cycle.
  - No RegWrite or MemWrite; instret unchanged.
- **Reset during MEMREAD of a lw:**
  - State returns to FETCH asynchronously and instret=0.
  - RegWrite is never asserted for the abandoned lw.
  - Next instruction executes normally.
